// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Supports fixed-select steering and round-robin arbitration over valid channels.
module stream_mux_n #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    mode_e            mode_sel;
    logic             load;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [W-1:0]     grant_data;

    logic [W-1:0]     data_q, data_d;
    logic [SELW-1:0]  chan_q, chan_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    assign mode_sel = mode_e'(mode);
    assign load     = !valid_q || out_ready;

    always_comb begin : grant_comb
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!rst) begin
            if (mode_sel == MODE_FIXED) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (i == 32'(sel) && in_valid[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = SELW'(i);
                    end
                end
            end else begin
                // Scan in reverse priority so the last hit is the first channel after ptr.
                for (int unsigned k = N; k >= 1; k--) begin
                    idx = 32'(ptr_q) + k;
                    if (idx >= N) idx = idx - N;
                    if (in_valid[idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = SELW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data  = in_data[i*W +: W];
                in_ready[i] = grant_vld && load;
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (grant_vld) begin
                data_d  = grant_data;
                chan_d  = grant_idx;
                valid_d = 1'b1;
                ptr_d   = grant_idx;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SELW'(N - 1);
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: behavioural model compared every cycle,
// directed scenarios with literal expectations, randomized traffic, and an N=3 drain case.
module tb_stream_mux_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        rst3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    stream_mux_n #(.N(4), .W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_n #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3), .mode(mode3), .out_data(out_data3), .out_chan(out_chan3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one output slot plus the last granted channel.
    bit       m_valid = 1'b0;
    int       m_data  = 0;
    int       m_chan  = 0;
    int       m_ptr   = 3;

    always @(negedge clk) begin
        if (chk_en) begin
            int  g;
            bit  ld;
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            chk("model_out_data", 32'(out_data), m_data);
            chk("model_out_chan", 32'(out_chan), m_chan);
            ld = !m_valid || out_ready;
            g  = -1;
            if (!rst) begin
                if (mode == 1'b0) begin
                    if (int'(sel) < 4 && in_valid[sel]) g = int'(sel);
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                    end
                end
            end
            chk("model_in_ready", 32'(in_ready), (g >= 0 && ld) ? (32'd1 << g) : 32'd0);
            if (rst) begin
                m_valid = 1'b0; m_data = 0; m_chan = 0; m_ptr = 3;
            end else if (ld) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = int'(in_data[g*8 +: 8]);
                    m_chan  = g;
                    m_ptr   = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] sweep_exp [4];
        int         rr_cnt [4];
        sweep_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        rr_cnt    = '{0, 0, 0, 0};

        rst = 1'b1; in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
        rst3 = 1'b1; in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b0;
        tick();
        tick();
        at_neg();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_out_chan", 32'(out_chan), 0);
        chk("reset_in_ready", 32'(in_ready), 0);
        tick();

        rst = 1'b0; in_data = 32'h44332211; in_valid = 4'hF; out_ready = 1'b1; mode = 1'b0;
        for (int s = 0; s <= 4; s++) begin
            if (s < 4) sel = 2'(s);
            at_neg();
            if (s < 4) chk("sweep_in_ready", 32'(in_ready), 32'd1 << s);
            if (s > 0) begin
                chk("sweep_out_data", 32'(out_data), 32'(sweep_exp[s-1]));
                chk("sweep_out_chan", 32'(out_chan), s - 1);
            end
            tick();
        end

        mode = 1'b1;
        for (int c = 0; c < 12; c++) begin
            at_neg();
            chk("rr_in_ready", 32'(in_ready), 32'd1 << (c % 4));
            for (int b = 0; b < 4; b++) rr_cnt[b] += int'(in_ready[b]);
            if (c > 0) chk("rr_out_chan", 32'(out_chan), (c - 1) % 4);
            tick();
        end
        for (int b = 0; b < 4; b++) chk("rr_ready_count", rr_cnt[b], 3);

        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("sparse_in_ready", 32'(in_ready), (c % 2 == 0) ? 32'h2 : 32'h8);
            chk("sparse_never_0_2", 32'(in_ready & 4'b0101), 0);
            tick();
        end

        mode = 1'b0; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; sel = 2'd2;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_data", 32'(out_data), 32'h22);
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        at_neg();
        chk("bp_release_in_ready", 32'(in_ready), 32'h4);
        chk("bp_release_hold", 32'(out_data), 32'h22);
        tick();
        at_neg();
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_data", 32'(out_data), 32'h33);
        chk("bp_next_chan", 32'(out_chan), 2);
        tick();

        mode = 1'b1; sel = 2'd0; in_valid = 4'hF;
        repeat (3) tick();
        rst = 1'b1;
        at_neg();
        chk("midrst_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        at_neg();
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_out_chan", 32'(out_chan), 0);
        chk("midrst_first_grant", 32'(in_ready), 32'h1);
        tick();
        at_neg();
        chk("midrst_chan_after", 32'(out_chan), 0);
        tick();

        for (int c = 0; c < 2000; c++) begin
            in_data   = $urandom;
            in_valid  = 4'($urandom);
            sel       = 2'($urandom);
            mode      = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        rst3 = 1'b1;
        tick();
        rst3 = 1'b0; in_data3 = 24'h332211; in_valid3 = 3'b111; sel3 = 2'd2;
        mode3 = 1'b0; out_ready3 = 1'b1;
        at_neg();
        chk("n3_in_ready", 32'(in_ready3), 32'h4);
        tick();
        sel3 = 2'd3;
        at_neg();
        chk("n3_badsel_in_ready", 32'(in_ready3), 0);
        chk("n3_word_present", 32'(out_valid3), 1);
        chk("n3_word_data", 32'(out_data3), 32'h33);
        tick();
        at_neg();
        chk("n3_drained_valid", 32'(out_valid3), 0);
        chk("n3_drained_data", 32'(out_data3), 32'h33);
        chk("n3_drained_chan", 32'(out_chan3), 2);
        chk("n3_drained_in_ready", 32'(in_ready3), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
